// File: rtl/stepgen_if.sv
// stepgen_if: command/feedback bundle between frame decode and the step/dir pins
interface stepgen_if #(
  parameter int JOINTS = 3
);
  logic [JOINTS*32-1:0] freq_cmd;
  logic [JOINTS-1:0]    enable;
  logic [JOINTS*32-1:0] position;
  logic [JOINTS-1:0]    step;
  logic [JOINTS-1:0]    dir;
  modport master (output freq_cmd, enable, input position, step, dir);
  modport slave  (input freq_cmd, enable, output position, step, dir);
endinterface

// File: rtl/stepgen_multi.sv
// stepgen_multi: per-joint DDS step/dir generator with pulse shaping, DIR setup and position feedback
module stepgen_multi #(
  parameter int JOINTS           = 3,
  parameter int ACC_BITS         = 32,
  parameter int PULSE_CYCLES     = 256,
  parameter int DIR_SETUP_CYCLES = 256
) (
  input logic      clk,
  input logic      rst,
  stepgen_if.slave s
);
  localparam int TMAX = PULSE_CYCLES > DIR_SETUP_CYCLES ? PULSE_CYCLES : DIR_SETUP_CYCLES;
  localparam int TW   = TMAX > 1 ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] T_PULSE = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] T_SETUP = TW'(DIR_SETUP_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;
  logic [JOINTS-1:0]    step_v, dir_v;
  logic [JOINTS*32-1:0] pos_v;
  assign s.step     = step_v;
  assign s.dir      = dir_v;
  assign s.position = pos_v;
  for (genvar j = 0; j < JOINTS; j++) begin : g_ch
    logic [31:0]         f, mag, pos_q, pos_d;
    logic [ACC_BITS:0]   sum;
    logic [ACC_BITS-1:0] acc_q, acc_d;
    logic [TW-1:0]       tmr_q, tmr_d;
    logic                en, req, fire;
    logic                pend_q, pend_d, pdir_q, pdir_d, step_q, step_d, dir_q, dir_d;
    state_t              st_q, st_d;
    assign f = s.freq_cmd[32*j +: 32];
    always_comb begin
      en     = s.enable[j];
      mag    = f[31] ? -f : f;
      sum    = {1'b0, acc_q} + {{(ACC_BITS - 31){1'b0}}, mag};
      req    = en && f != 0 && sum[ACC_BITS];
      acc_d  = !en ? '0 : f != 0 ? sum[ACC_BITS-1:0] : acc_q;
      fire   = 1'b0;
      st_d   = st_q;
      tmr_d  = tmr_q;
      dir_d  = dir_q;
      case (st_q)
        IDLE:
          if (pend_q && pdir_q == dir_q) begin
            fire  = 1'b1;
            tmr_d = T_PULSE;
            st_d  = HIGH;
          end else if (pend_q) begin
            dir_d = pdir_q;
            tmr_d = T_SETUP;
            st_d  = SETUP;
          end
        SETUP:
          if (tmr_q != 0) tmr_d = tmr_q - TW'(1);
          else if (pend_q) begin
            fire  = 1'b1;
            tmr_d = T_PULSE;
            st_d  = HIGH;
          end else st_d = IDLE;
        HIGH:
          if (tmr_q != 0) tmr_d = tmr_q - TW'(1);
          else begin
            tmr_d = T_PULSE;
            st_d  = LOW;
          end
        LOW:
          if (tmr_q != 0) tmr_d = tmr_q - TW'(1);
          else st_d = IDLE;
        default: st_d = IDLE;
      endcase
      step_d = fire || (step_q && !(st_q == HIGH && tmr_q == 0));
      pos_d  = fire ? pos_q + (dir_q ? 32'd1 : '1) : pos_q;
      // one-deep buffer: a consumed slot accepts a same-cycle request, a full one drops it
      pend_d = !en ? 1'b0 : req ? 1'b1 : pend_q && !fire;
      pdir_d = req && (!pend_q || fire) ? ~f[31] : pdir_q;
    end
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        acc_q  <= '0;
        pend_q <= 1'b0;
        pdir_q <= 1'b0;
        st_q   <= IDLE;
        tmr_q  <= '0;
        step_q <= 1'b0;
        dir_q  <= 1'b0;
        pos_q  <= '0;
      end else begin
        acc_q  <= acc_d;
        pend_q <= pend_d;
        pdir_q <= pdir_d;
        st_q   <= st_d;
        tmr_q  <= tmr_d;
        step_q <= step_d;
        dir_q  <= dir_d;
        pos_q  <= pos_d;
      end
    assign step_v[j]          = step_q;
    assign dir_v[j]           = dir_q;
    assign pos_v[32*j +: 32]  = pos_q;
  end
endmodule

// File: doc/stepgen_multi.md
Name: stepgen_multi

Overview:
- Parametrised multi-joint step/direction generator for the Remora motion path.
- One DDS phase accumulator per joint replaces the counter/divider stepgen. Each joint adds a per-joint enable, a minimum step-pulse width, DIR-to-STEP setup time, single-request buffering and a 32-bit position feedback counter.
- Sits between the SPI frame decode (freq commands, enables) and the STP/DIR pins. Its position words return in the tx frame.

Parameters:
- JOINTS, 3, number of independent step channels (1..8)
- ACC_BITS, 32, phase accumulator width (>=32)
- PULSE_CYCLES, 256, clk cycles of STEP high and minimum STEP low (>=1)
- DIR_SETUP_CYCLES, 256, clk cycles DIR must be stable before a STEP rising edge (>=1)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- freq_cmd  in  JOINTS*32  signed two's-complement phase increment per joint; joint j = bits [32j+31:32j]
- enable  in  JOINTS  per-joint enable
- position  out  JOINTS*32  signed step count per joint, same packing as freq_cmd
- step  out  JOINTS  step pulse, registered
- dir  out  JOINTS  direction, 1 = positive, registered

Behaviour:
Interface and reset:
- One clock domain. Reset is asynchronous and active-high.
- While rst is high: acc=0, pending=0, state=IDLE, timer=0, step=0, dir=0, position=0. No pulse survives reset, including one mid-pulse.

Accumulator, per joint, each cycle:
- mag = |freq_cmd|, as a 32-bit unsigned value zero-extended to ACC_BITS. -2^31 gives 2^31.
- If enable=1 and freq_cmd!=0: {carry, acc} <= acc + mag. Otherwise acc holds.
- If enable=0: acc <= 0 and pending <= 0.
- A carry out of the MSB is a step request. The requested direction is req_dir = ~freq_cmd[31], captured in the same cycle.
- A sign change of freq_cmd does not clear acc (phase continuity).

Request buffer, one deep:
- A request with pending=0 sets pending=1 and stores pend_dir=req_dir.
- A request arriving while pending=1 is dropped silently (overrun).
- Same-cycle request and consumption: the consumed request leaves and the new one is stored.

State machine, per joint, with a shared-width down-counter:
- IDLE: step=0. If pending=1 and pend_dir==dir: consume the request, step<=1, update position, timer<=PULSE_CYCLES-1, go HIGH. If pending=1 and pend_dir!=dir: dir<=pend_dir, timer<=DIR_SETUP_CYCLES-1, go SETUP; the request stays pending.
- SETUP: count down. At timer==0, if pending still set: consume, step<=1, update position, go HIGH. If pending was cleared by enable=0, go IDLE.
- HIGH: count down. At 0: step<=0, timer<=PULSE_CYCLES-1, go LOW.
- LOW: count down. At 0, go IDLE. IDLE may start the next pulse on the following edge.
- enable=0 does not abort HIGH or LOW: a started pulse completes with full width. SETUP aborts to IDLE with dir kept.
- dir changes only in IDLE.

Position and timing:
- Position update happens on the same edge as step's rising edge: +1 if dir=1, -1 if dir=0. Arithmetic is modulo 2^32 (wraps 0x7FFFFFFF -> 0x80000000).
- Latency: a carry on edge k with the state IDLE and dir matching gives step high after edge k+1.
- STEP high time is exactly PULSE_CYCLES. Minimum STEP period is 2*PULSE_CYCLES+1 cycles. Higher commanded rates saturate at that rate.
- Channels are fully independent. Changing JOINTS replicates the logic only.

Test Plan (JOINTS=2, ACC_BITS=32, PULSE_CYCLES=4, DIR_SETUP_CYCLES=8):
1. Reset: rst=1 for 3 cycles, enable=2'b11, freq=0 -> step=0, dir=0, position=0. Assert rst mid-HIGH -> step drops asynchronously and position returns to 0.
2. Forward steady rate: ch0 freq=+2^28, enable=1. From reset, dir 0->1 first, then the first step 8 cycles later. Thereafter one step every 16 cycles, step high exactly 4 cycles, position +1 per rising edge: 10 steps -> 10. ch1 stays idle.
3. Reverse: ch1 freq=-2^28 from reset -> dir stays 0, no setup delay, position decrements by 1 per step to -5 (0xFFFFFFFB) after 5 steps.
4. Direction reversal: ch0 running at +2^28, switch to -2^28 -> dir falls only in IDLE. The next rising step occurs no earlier than 8 cycles after dir changes. Position counts down from the last value.
5. Overrun: freq=+2^31 (carry every 2 cycles) -> step period 9 cycles, high 4 cycles. Extra requests are dropped, so position increases by 1 per 9 cycles, not 1 per 2.
6. Enable drop: deassert enable during cycle 2 of HIGH -> step stays high 2 more cycles, then LOW completes and no further pulses occur. acc=0, position held. Re-enable with pending=0 -> the first step needs a fresh carry.
